// File: rtl/param_alu_acc.sv
// Registered 8-operation ALU with accumulator feedback, a multi-cycle shift-add
// multiplier and a 7-segment status/glyph output.
module param_alu_acc #(
  parameter int NBITS = 8,
  parameter int CNTW  = $clog2(NBITS) + 1
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result,
  output logic             ovf,
  output logic             unf,
  output logic             zero,
  output logic [7:0]       seg
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t             state_reg;
  logic [NBITS-1:0]   result_reg;
  logic               ovf_reg;
  logic               unf_reg;
  logic               done_reg;
  logic               busy_reg;
  logic [CNTW-1:0]    cnt_reg;
  logic [2*NBITS-1:0] mcand_reg;
  logic [2*NBITS-1:0] prod_reg;
  logic [NBITS-1:0]   mplier_reg;

  logic [NBITS-1:0]   opa;
  logic [NBITS:0]     sum;
  logic [NBITS-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_unf;
  logic [2*NBITS-1:0] prod_next;

  // Accumulator mode feeds the registered result back as operand A.
  assign opa = acc_sel ? result_reg : a;
  assign sum = {1'b0, opa} + {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_unf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[NBITS-1:0];
        alu_ovf = sum[NBITS];
      end
      OP_SUB: begin
        alu_res = opa - b;
        alu_unf = (opa < b);
      end
      OP_AND: alu_res = opa & b;
      OP_OR:  alu_res = opa | b;
      OP_XOR: alu_res = opa ^ b;
      OP_SHL: begin
        alu_res = {opa[NBITS-2:0], 1'b0};
        alu_ovf = opa[NBITS-1];
      end
      OP_SHR: alu_res = {1'b0, opa[NBITS-1:1]};
      default: alu_res = '0;
    endcase
  end

  assign prod_next = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      mplier_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand_reg  <= {{NBITS{1'b0}}, opa};
              mplier_reg <= b;
              prod_reg   <= '0;
              cnt_reg    <= CNTW'(NBITS);
              busy_reg   <= 1'b1;
              state_reg  <= MUL;
            end else begin
              result_reg <= alu_res;
              ovf_reg    <= alu_ovf;
              unf_reg    <= alu_unf;
              done_reg   <= 1'b1;
            end
          end
        end
        MUL: begin
          prod_reg   <= prod_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg - 1'b1;
          // Last iteration: commit the product including this cycle's add.
          if (cnt_reg == CNTW'(1)) begin
            result_reg <= prod_next[NBITS-1:0];
            ovf_reg    <= |prod_next[2*NBITS-1:NBITS];
            unf_reg    <= 1'b0;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign result = result_reg;
  assign ovf    = ovf_reg;
  assign unf    = unf_reg;
  assign done   = done_reg;
  assign busy   = busy_reg;
  assign zero   = (result_reg == '0);

  always_comb begin
    seg = 8'h3F;
    if (ovf_reg) begin
      seg = 8'hBF;
    end else if (unf_reg) begin
      seg = 8'hBE;
    end else begin
      case (result_reg[3:0])
        4'h0: seg = 8'h3F;
        4'h1: seg = 8'h06;
        4'h2: seg = 8'h5B;
        4'h3: seg = 8'h4F;
        4'h4: seg = 8'h66;
        4'h5: seg = 8'h6D;
        4'h6: seg = 8'h7D;
        4'h7: seg = 8'h07;
        4'h8: seg = 8'h7F;
        4'h9: seg = 8'h6F;
        4'hA: seg = 8'h77;
        4'hB: seg = 8'h7C;
        4'hC: seg = 8'h39;
        4'hD: seg = 8'h5E;
        4'hE: seg = 8'h79;
        default: seg = 8'h71;
      endcase
    end
  end

endmodule

// File: tb/tb_param_alu_acc.sv
// Directed plus randomized bench for param_alu_acc against an arithmetic reference model.
module tb_param_alu_acc;

  localparam int NB = 8;
  localparam int unsigned MASK = (1 << NB) - 1;

  logic          clk_2 = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic          acc_sel;
  logic [NB-1:0] a;
  logic [NB-1:0] b;
  logic          busy;
  logic          done;
  logic [NB-1:0] result;
  logic          ovf;
  logic          unf;
  logic          zero;
  logic [7:0]    seg;

  int checks = 0;
  int errors = 0;

  int unsigned m_res = 0;
  int unsigned m_ovf = 0;
  int unsigned m_unf = 0;

  param_alu_acc #(.NBITS(NB)) dut (
    .clk_2(clk_2), .rst_n(rst_n), .start(start), .op(op), .acc_sel(acc_sel),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .ovf(ovf), .unf(unf), .zero(zero), .seg(seg)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input int unsigned r, input int unsigned o, input int unsigned u);
    if (o != 0) return 8'hBF;
    if (u != 0) return 8'hBE;
    case (r % 16)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;  10: return 8'h77; 11: return 8'h7C;
      12: return 8'h39; 13: return 8'h5E; 14: return 8'h79; default: return 8'h71;
    endcase
  endfunction

  // Reference: what the registered result/flags become after an operation.
  task automatic model_op(input int o, input bit acc, input int unsigned av, input int unsigned bv);
    int unsigned opnd_a;
    longint unsigned p;
    opnd_a = acc ? m_res : av;
    m_ovf = 0;
    m_unf = 0;
    case (o)
      0: begin p = longint'(opnd_a) + bv; m_res = int'(p) & MASK; m_ovf = (p > MASK) ? 1 : 0; end
      1: begin m_res = (opnd_a - bv) & MASK; m_unf = (opnd_a < bv) ? 1 : 0; end
      2: m_res = opnd_a & bv;
      3: m_res = opnd_a | bv;
      4: m_res = opnd_a ^ bv;
      5: begin p = longint'(opnd_a) * 2; m_res = int'(p) & MASK; m_ovf = (p > MASK) ? 1 : 0; end
      6: m_res = opnd_a / 2;
      default: begin p = longint'(opnd_a) * bv; m_res = int'(p) & MASK; m_ovf = (p > MASK) ? 1 : 0; end
    endcase
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_res"},  result, m_res);
    chk({tag, "_ovf"},  ovf, m_ovf);
    chk({tag, "_unf"},  unf, m_unf);
    chk({tag, "_zero"}, zero, (m_res == 0) ? 1 : 0);
    chk({tag, "_seg"},  seg, glyph(m_res, m_ovf, m_unf));
  endtask

  task automatic run_op(input int o, input bit acc, input int unsigned av, input int unsigned bv, input string tag);
    op = 3'(o); acc_sel = acc; a = NB'(av); b = NB'(bv); start = 1'b1;
    model_op(o, acc, av, bv);
    @(posedge clk_2); #1;
    start = 1'b0;
    if (o == 7) begin
      chk({tag, "_busy1"}, busy, 1);
      chk({tag, "_nodone1"}, done, 0);
      for (int k = 2; k <= NB + 1; k++) begin
        // Noise during the multiply must be ignored.
        start = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 7));
        acc_sel = 1'($urandom_range(0, 1)); a = NB'($urandom); b = NB'($urandom);
        @(posedge clk_2); #1;
        if (k <= NB) begin
          chk({tag, "_busy"}, busy, 1);
          chk({tag, "_nodone"}, done, 0);
        end
      end
      start = 1'b0;
      chk({tag, "_busy_end"}, busy, 0);
    end
    check_out(tag);
    $display("op=%0d acc=%0b a=%0d b=%0d -> result=%0d ovf=%0b unf=%0b seg=%02h",
             o, acc, av, bv, result, ovf, unf, seg);
    @(posedge clk_2); #1;
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_hold"}, result, m_res);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; acc_sel = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_res", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_seg", seg, 8'h3F);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk_2); rst_n = 1'b1;
    @(posedge clk_2); #1;

    run_op(0, 0, 200, 100, "add_ovf");
    chk("add_ovf_const", result, 44);
    run_op(0, 0, 3, 4, "add");
    chk("add_seg_const", seg, 8'h07);
    run_op(1, 0, 5, 9, "sub_unf");
    chk("sub_unf_const", seg, 8'hBE);
    run_op(1, 0, 9, 9, "sub_zero");
    chk("sub_zero_const", seg, 8'h3F);
    run_op(7, 0, 13, 11, "mul");
    chk("mul_const", result, 143);
    run_op(7, 0, 20, 20, "mul_ovf");
    chk("mul_ovf_const", result, 144);

    run_op(0, 0, 1, 0, "acc_seed");
    op = 3'd5; acc_sel = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      model_op(5, 1, 0, 0);
      @(posedge clk_2); #1;
      check_out("acc_shl");
      $display("acc shl1 step %0d -> result=%0d ovf=%0b zero=%0b", i, result, ovf, zero);
    end
    start = 1'b0; acc_sel = 1'b0;
    chk("acc_final_ovf", ovf, 1);
    chk("acc_final_zero", zero, 1);
    @(posedge clk_2); #1;

    run_op(2, 0, 8'hF0, 8'h3C, "and");
    chk("and_const", result, 8'h30);
    run_op(3, 0, 8'hF0, 8'h3C, "or");
    chk("or_const", result, 8'hFC);
    run_op(4, 0, 8'hF0, 8'h3C, "xor");
    chk("xor_seg_const", seg, 8'h39);
    run_op(6, 0, 8'hF0, 8'h3C, "shr");
    chk("shr_seg_const", seg, 8'h7F);

    // Asynchronous reset while the multiplier counter sits at 3.
    op = 3'd7; acc_sel = 1'b0; a = 8'd13; b = 8'd11; start = 1'b1;
    @(posedge clk_2); #1;
    start = 1'b0;
    repeat (5) @(posedge clk_2);
    #2;
    rst_n = 1'b0;
    #1;
    m_res = 0; m_ovf = 0; m_unf = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_res", result, 0);
    chk("midrst_zero", zero, 1);
    chk("midrst_seg", seg, 8'h3F);
    chk("midrst_done", done, 0);
    $display("reset asserted mid-multiply -> busy=%0b result=%0d seg=%02h", busy, result, seg);
    @(negedge clk_2); rst_n = 1'b1;
    @(posedge clk_2); #1;
    chk("postrst_idle", done, 0);
    run_op(0, 0, 0, 0, "postrst_add");

    for (int i = 0; i < 30; i++) begin
      run_op(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             $urandom_range(0, MASK), $urandom_range(0, MASK), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_alu_acc.md
Name: param_alu_acc

Overview:
- Parametrised, registered successor to the switch-driven 4-way ALU mux.
- Eight operations on NBITS-wide operands, including a multi-cycle shift-add multiply.
- Registered result with carry/borrow/zero flags and an accumulator mode that feeds the last result back as operand A.
- Drives a 7-segment pattern for the LED/SEG board outputs in top.

Parameters:
- NBITS, 8, operand/result width (>=4).
- CNTW, $clog2(NBITS)+1, multiply iteration counter width.

Ports:
- clk_2  input  1  system clock (divided board clock).
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled on rising clk_2 only when busy=0.
- op  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl1, 110 shr1, 111 mul.
- acc_sel  input  1  1: operand A = result register; 0: operand A = a.
- a  input  NBITS  operand A.
- b  input  NBITS  operand B.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse; result and flags valid and updated.
- result  output  NBITS  registered result.
- ovf  output  1  carry-out (add, shl1) or high product half nonzero (mul).
- unf  output  1  borrow (sub, A<B unsigned).
- zero  output  1  result==0.
- seg  output  8  7-seg pattern, bit7=dp, bits6:0=gfedcba, active high.

Behaviour:
- Reset, asynchronous on rst_n=0, effective immediately including mid-multiply:
  - FSM to IDLE.
  - result=0, ovf=0, unf=0, busy=0, done=0, counter and partial product cleared.
  - zero=1, seg=8'h3F.
- FSM states: IDLE, MUL.
- IDLE with start=1 and op!=111 (single-cycle path):
  - Compute on sampled A/B.
  - Next edge: result, flags and done=1 update together (latency 1).
  - Stay in IDLE.
- IDLE with start=1 and op=111 (multiply launch):
  - Latch multiplicand A and multiplier B.
  - Clear the 2*NBITS partial product and set counter=NBITS.
  - Go to MUL; busy=1 from the next edge.
- MUL, each cycle:
  - If multiplier LSB is 1, add the multiplicand (shifted) to the partial product.
  - Shift, then decrement the counter.
  - When counter reaches 0 (after NBITS cycles in MUL): result = low NBITS of product, ovf = |high NBITS, unf=0, done=1, busy=0, return to IDLE.
  - Total latency start-to-done = NBITS+1 edges.
- start while busy=1 is ignored and not queued; a, b, op and acc_sel changes during MUL have no effect.
- done is high only on the single edge where result updates; otherwise 0.
- Arithmetic and flags (unsigned, NBITS wide):
  - add: {ovf,result} = A+B, unf=0.
  - sub: result = A-B mod 2^NBITS, unf = A<B, ovf=0.
  - and/or/xor: ovf=unf=0.
  - shl1: result = A<<1, ovf = A[NBITS-1].
  - shr1: result = A>>1, logical, ovf=unf=0.
- acc_sel=1: A is the result register value at the start edge. Back-to-back starts (start held high) chain every cycle on the single-cycle path.
- zero and seg are combinational from registered state:
  - seg = 8'hBF if ovf.
  - else seg = 8'hBE if unf.
  - else seg = hex glyph of result[3:0]:
    - 0-7: 3F,06,5B,4F,66,6D,7D,07
    - 8-F: 7F,6F,77,7C,39,5E,79,71
- Flags hold their value until the next done.

Test Plan:
- NBITS=8. Reset asserted mid-MUL (counter=3) → same cycle busy=0, result=0, zero=1, seg=3F. After release, a start with op=000, a=0, b=0 gives done with result=0.
- op=000, a=200, b=100, start pulse → next edge done=1, result=44, ovf=1, seg=BF. Then a=3, b=4 → result=7, ovf=0, seg=07.
- op=001, a=5, b=9 → result=252, unf=1, seg=BE. Then a=9, b=9 → result=0, zero=1, unf=0, seg=3F.
- op=111, a=13, b=11 → busy high for 8 cycles, start pulses during busy ignored. done on 9th edge, result=143, ovf=0. Then a=20, b=20 → result=144, ovf=1.
- Accumulator: result=1, acc_sel=1, op=101, start held 8 cycles → result 2,4,8,…,128, then 0 with ovf=1 and zero=1 on the 8th.
- Logic ops: a=8'hF0, b=8'h3C → and=30, or=FC, xor=CC (seg 39), shr1 of F0=78 (seg 7F); flags 0 each time.
